counter_updown_mod: RTL
=======================

COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

Interface
REQ-001 Parameter Size, default 5: width of count, load_value in bits, 1..32.
REQ-002 Parameter Modulus, default 32: count range 0..Modulus-1; legal 2..2**Size.
REQ-003 Parameter Prescale, default 1: enabled cycles per count step; legal 1..65536.
REQ-004 Parameter Saturate, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  advances prescaler when high.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 load  input  1  synchronous load of load_value.
REQ-010 load_value  input  Size  value loaded when load is high.
REQ-011 clear_flags  input  1  clears sticky overflow.
REQ-012 count  output  Size  current count, registered.
REQ-013 terminal  output  1  registered one-cycle pulse on a boundary step.
REQ-014 overflow  output  1  sticky boundary-event flag, registered.

Function
REQ-015 Internal tick counter range 0..Prescale-1; with Prescale=1, the step condition is simply enable.
REQ-016 Step condition: enable high AND tick == Prescale-1; tick then returns to 0.
REQ-017 enable high without step: tick increments; enable low: tick and count hold.
REQ-018 Priority per edge: reset > load > step > hold.
REQ-019 load: count <= min(load_value, Modulus-1); tick <= 0; overflow <= 0; terminal <= 0; enable ignored that cycle.
REQ-020 Step up, count < Modulus-1: count <= count+1.
REQ-021 Step up, count == Modulus-1: count <= 0 (Saturate=0) or holds (Saturate=1); boundary event.
REQ-022 Step down, count > 0: count <= count-1.
REQ-023 Step down, count == 0: count <= Modulus-1 (Saturate=0) or holds (Saturate=1); boundary event.
REQ-024 terminal is high exactly in the cycle following the edge that took a boundary-event step; low otherwise.
REQ-025 Boundary events on consecutive steps give terminal high on consecutive cycles (no merging or suppression).
REQ-026 overflow sets on the edge of any boundary event and stays set until clear_flags, load, or reset.
REQ-027 clear_flags and boundary event on same edge: overflow = 1 (set wins).
REQ-028 clear_flags does not affect count, tick or terminal.
REQ-029 up may change on any cycle; direction applies only at the step edge on which it is sampled.
REQ-030 Arithmetic is modular within Size bits; no intermediate result wider than Size+1 bits; count never leaves 0..Modulus-1.
REQ-031 Latency: count, terminal and overflow reflect a step or load on the rising edge that samples it (one-cycle registered).

Reset
REQ-032 reset low asynchronously forces count = 0, tick = 0, terminal = 0, overflow = 0 without a clock edge.
REQ-033 Reset asserted mid-prescale or mid-step discards partial tick; first step after release needs a full Prescale enabled cycles.
REQ-034 Deassertion is sampled synchronously; the first edge with reset high may perform a load or step.

Verification
REQ-035 Defaults, enable=1 up=1 for 33 cycles from reset -> count 0..31, then 0; terminal one pulse after the 31->0 edge; overflow = 1.
REQ-036 Modulus=10, Saturate=1, load 3, enable=1 up=0 for 5 cycles -> count 2,1,0,0,0; terminal pulses twice; overflow = 1; load 15 -> count 9, overflow 0.
REQ-037 Prescale=4, enable=1 up=1 -> count increments every 4th cycle; enable low for 2 cycles mid-period -> step delayed by 2 cycles.
REQ-038 load and enable high same edge with count=7 -> count = load_value, no step, tick = 0.
REQ-039 count=31 up=1 step with clear_flags=1 on same edge -> count 0, overflow 1; next cycle clear_flags=1 -> overflow 0.
REQ-040 Assert reset between clock edges at count=17 -> count 0 immediately; after release count resumes from 0.

Source files
------------

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with enable prescaler, synchronous load, optional saturation,
// a one-cycle terminal pulse on every boundary step and a sticky overflow flag.
module counter_updown_mod #(
    parameter int              Size     = 5,
    parameter longint unsigned Modulus  = 64'd32,
    parameter int              Prescale = 1,
    parameter bit              Saturate = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    input  logic            clear_flags,
    output logic [Size-1:0] count,
    output logic            terminal,
    output logic            overflow
);

    localparam int              TickW     = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(Prescale - 1);
    localparam logic [Size-1:0]  CountMax = Size'(Modulus - 64'd1);

    logic [Size-1:0]  count_r;
    logic [TickW-1:0] tick_r;
    logic             terminal_r;
    logic             overflow_r;

    logic [Size-1:0]  count_s;
    logic [TickW-1:0] tick_s;
    logic             terminal_s;
    logic             overflow_s;
    logic             step_s;
    logic             boundary_s;
    logic [Size-1:0]  load_clamp_s;

    assign count    = count_r;
    assign terminal = terminal_r;
    assign overflow = overflow_r;

    // Step qualification, boundary detection and load clamping.
    always_comb begin
        step_s       = enable && (tick_r == TickLast);
        boundary_s   = step_s && (up ? (count_r == CountMax) : (count_r == {Size{1'b0}}));
        load_clamp_s = (load_value > CountMax) ? CountMax : load_value;
    end

    // Next-state selection: load beats step, step beats hold.
    always_comb begin
        count_s    = count_r;
        tick_s     = tick_r;
        terminal_s = 1'b0;
        overflow_s = overflow_r;
        if (load) begin
            count_s    = load_clamp_s;
            tick_s     = {TickW{1'b0}};
            overflow_s = 1'b0;
        end else if (step_s) begin
            tick_s     = {TickW{1'b0}};
            terminal_s = boundary_s;
            if (up) begin
                if (count_r == CountMax) begin
                    count_s = Saturate ? count_r : {Size{1'b0}};
                end else begin
                    count_s = count_r + Size'(1'b1);
                end
            end else begin
                if (count_r == {Size{1'b0}}) begin
                    count_s = Saturate ? count_r : CountMax;
                end else begin
                    count_s = count_r - Size'(1'b1);
                end
            end
            // A boundary event outranks a simultaneous clear request.
            if (boundary_s) begin
                overflow_s = 1'b1;
            end else if (clear_flags) begin
                overflow_s = 1'b0;
            end else begin
                overflow_s = overflow_r;
            end
        end else begin
            if (enable) begin
                tick_s = tick_r + TickW'(1'b1);
            end else begin
                tick_s = tick_r;
            end
            if (clear_flags) begin
                overflow_s = 1'b0;
            end else begin
                overflow_s = overflow_r;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r    <= {Size{1'b0}};
            tick_r     <= {TickW{1'b0}};
            terminal_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_s;
            tick_r     <= tick_s;
            terminal_r <= terminal_s;
            overflow_r <= overflow_s;
        end
    end

endmodule
